// File: rtl/sdio_dat_serializer_if.sv
// Byte handshake, control and pad-side signals of one SDIO DAT line transmitter.
interface sdio_dat_serializer_if;
  logic        i_ce;
  logic        i_start;
  logic        i_abort;
  logic [11:0] i_block_size;
  logic [7:0]  i_data;
  logic        i_data_stb;
  logic        o_data_rdy;
  logic        o_sd_dat;
  logic        o_sd_oe;
  logic        o_busy;
  logic        o_done;
  logic        o_underrun;

  // Driver side: byte source, controller and SD-clock tick generator.
  modport master (
    output i_ce, i_start, i_abort, i_block_size, i_data, i_data_stb,
    input  o_data_rdy, o_sd_dat, o_sd_oe, o_busy, o_done, o_underrun
  );

  // Serializer side.
  modport slave (
    input  i_ce, i_start, i_abort, i_block_size, i_data, i_data_stb,
    output o_data_rdy, o_sd_dat, o_sd_oe, o_busy, o_done, o_underrun
  );
endinterface

// File: rtl/sdio_dat_serializer.sv
// SDIO DAT0 transmitter, 1-bit mode: start bit, MSB-first payload, inline CRC16, end bit.
// Line, CRC and state advance only on SD-clock ticks (i_ce).
module sdio_dat_serializer #(
  parameter logic [15:0] POLYNOMIAL = 16'h1021,
  parameter logic [15:0] SEED       = 16'h0000
) (
  input logic                  clk,
  input logic                  rst,
  sdio_dat_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StCrc, StEnd, StDone, StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] crc_q, crc_d;
  logic [11:0] cnt_q, cnt_d;   // bytes still to move into the shift register
  logic [3:0]  bit_q, bit_d;   // bit index within byte (DATA) or CRC field (CRC)
  logic        dat_q, dat_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        unr_q, unr_d;
  logic        fb;

  // Next-state, datapath and registered pad outputs.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    dat_d      = dat_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    unr_d      = unr_q;
    fb         = crc_q[15] ^ shift_q[7];

    if (bus.i_abort) begin
      // Abort wins over everything, including a byte offered on this clock.
      state_d    = StAbort;
      dat_d      = 1'b1;
      oe_d       = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      // Holding register accepts bytes in any state, IDLE included (prefetch).
      if (bus.i_data_stb && !hold_vld_q) begin
        hold_d     = bus.i_data;
        hold_vld_d = 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (bus.i_start && (bus.i_block_size != 12'd0)) begin
            state_d = StStart;
            cnt_d   = bus.i_block_size;
            crc_d   = SEED;
            bit_d   = 4'd0;
            unr_d   = 1'b0;
          end
        end
        StStart: begin
          if (bus.i_ce) begin
            dat_d = 1'b0;
            oe_d  = 1'b1;
            bit_d = 4'd0;
            if (!hold_vld_q) begin
              unr_d   = 1'b1;
              state_d = StAbort;
            end else begin
              shift_d    = hold_q;
              hold_vld_d = 1'b0;
              cnt_d      = cnt_q - 12'd1;
              state_d    = StData;
            end
          end
        end
        StData: begin
          if (bus.i_ce) begin
            dat_d   = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            crc_d   = {crc_q[14:0], 1'b0} ^ (fb ? POLYNOMIAL : 16'h0000);
            if (bit_q == 4'd7) begin
              bit_d = 4'd0;
              if (cnt_q == 12'd0) begin
                state_d = StCrc;
              end else if (hold_vld_q) begin
                shift_d    = hold_q;
                hold_vld_d = 1'b0;
                cnt_d      = cnt_q - 12'd1;
              end else begin
                unr_d   = 1'b1;
                state_d = StAbort;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        StCrc: begin
          if (bus.i_ce) begin
            dat_d = crc_q[15];
            crc_d = {crc_q[14:0], 1'b0};
            if (bit_q == 4'd15) begin
              bit_d   = 4'd0;
              state_d = StEnd;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        StEnd: begin
          if (bus.i_ce) begin
            dat_d   = 1'b1;
            oe_d    = 1'b1;
            state_d = StDone;
          end
        end
        StDone: begin
          done_d  = 1'b1;
          dat_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = StIdle;
        end
        StAbort: begin
          dat_d      = 1'b1;
          oe_d       = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = StIdle;
        end
        default: begin
          dat_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      shift_q    <= 8'h00;
      crc_q      <= SEED;
      cnt_q      <= 12'd0;
      bit_q      <= 4'd0;
      dat_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      dat_q      <= dat_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      unr_q      <= unr_d;
    end
  end

  assign bus.o_data_rdy = !hold_vld_q;
  assign bus.o_sd_dat   = dat_q;
  assign bus.o_sd_oe    = oe_q;
  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_done     = done_q;
  assign bus.o_underrun = unr_q;

endmodule

// File: tb/tb_sdio_dat_serializer.sv
// Bench for sdio_dat_serializer: model builds the expected DAT0 bit stream per block,
// a monitor compares every driven tick against it.
module tb_sdio_dat_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdio_dat_serializer_if bus();

  sdio_dat_serializer #(
    .POLYNOMIAL(16'h1021),
    .SEED      (16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] pay_q[$];
  bit         exp_bits[$];

  // Byte-wise CRC16-CCITT (XMODEM form) over pay_q.
  function automatic logic [15:0] model_crc();
    logic [15:0] c = 16'h0000;
    foreach (pay_q[i]) begin
      c = c ^ {pay_q[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Expected frame: start 0, payload MSB first, CRC MSB first, end 1.
  function automatic logic [15:0] build_frame();
    logic [15:0] c = model_crc();
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    foreach (pay_q[i]) for (int k = 7; k >= 0; k--) exp_bits.push_back(pay_q[i][k]);
    for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
    exp_bits.push_back(1'b1);
    return c;
  endfunction

  // ---------------- SD-clock tick ----------------
  int ce_div   = 1;
  int ce_phase = 0;
  always @(negedge clk) begin
    ce_phase = (ce_phase + 1 >= ce_div) ? 0 : ce_phase + 1;
    bus.i_ce = (ce_phase == 0);
  end

  // ---------------- byte feeder ----------------
  logic [7:0] tx_q[$];
  bit feed_en = 1'b1;
  bit acc     = 1'b0;
  always @(negedge clk) begin
    if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
    bus.i_data_stb = feed_en && (tx_q.size() > 0);
    bus.i_data     = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    acc            = bus.i_data_stb && bus.o_data_rdy && !bus.i_abort;
  end

  // ---------------- compare process ----------------
  int oe_ticks = 0;
  int done_cnt = 0;
  bit ce_s;
  always @(posedge clk) begin
    ce_s = bus.i_ce;
    #1;
    if (!rst) begin
      if (bus.o_done) done_cnt++;
      if (bus.o_sd_oe) begin
        if (ce_s) begin
          oe_ticks++;
          if (exp_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL line_extra: driven bit %0b with no bit expected at %0t",
                     bus.o_sd_dat, $time);
          end else begin
            check("line_bit", {31'd0, bus.o_sd_dat}, {31'd0, exp_bits.pop_front()});
          end
        end
      end else begin
        check("line_idle", {31'd0, bus.o_sd_dat}, 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input int n, input logic [7:0] base, input logic [7:0] step,
                        input int div, output logic [15:0] crc);
    logic [7:0] b = base;
    ce_div = div;
    pay_q.delete();
    for (int i = 0; i < n; i++) begin
      pay_q.push_back(b);
      b = b + step;
    end
    crc = build_frame();
    foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
    oe_ticks = 0;
    done_cnt = 0;
    @(negedge clk);
    bus.i_block_size = n[11:0];
    bus.i_start      = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("start_busy", {31'd0, bus.o_busy}, 32'd1);
    check("start_unr_clr", {31'd0, bus.o_underrun}, 32'd0);
  endtask

  // Full block; poke > 0 issues a start (size 5) mid-block that must be ignored.
  task automatic run_block(input int n, input logic [7:0] base, input logic [7:0] step,
                           input int div, input int poke, output logic [15:0] crc);
    int t = 0;
    launch(n, base, step, div, crc);
    while (done_cnt == 0 && t < 50000) begin
      @(negedge clk);
      t++;
      bus.i_start      = (t == poke);
      bus.i_block_size = (t == poke) ? 12'd5 : n[11:0];
    end
    bus.i_start = 1'b0;
    if (t >= 50000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no o_done after %0d clks", t);
    end
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 32'd1);
    check("oe_ticks", oe_ticks, 8 * n + 18);
    check("bits_left", exp_bits.size(), 32'd0);
    check("end_busy", {31'd0, bus.o_busy}, 32'd0);
    check("end_unr", {31'd0, bus.o_underrun}, 32'd0);
  endtask

  task automatic drain();
    feed_en = 1'b0;
    repeat (2) @(negedge clk);
    tx_q.delete();
    exp_bits.delete();
    feed_en = 1'b1;
  endtask

  logic [15:0] crc;
  int t;

  initial begin
    bus.i_ce         = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_block_size = 12'd0;
    bus.i_data       = 8'h00;
    bus.i_data_stb   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dat", {31'd0, bus.o_sd_dat}, 32'd1);
    check("rst_oe", {31'd0, bus.o_sd_oe}, 32'd0);
    check("rst_rdy", {31'd0, bus.o_data_rdy}, 32'd1);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    check("rst_unr", {31'd0, bus.o_underrun}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1 byte 0x00, tick every clk: 26 ticks, CRC 0x0000
    run_block(1, 8'h00, 8'h00, 1, 0, crc);
    check("crc_00", crc, 32'h0000);
    check("ticks_00", oe_ticks, 32'd26);

    // 1 byte 0x01: CRC field 0x1021
    run_block(1, 8'h01, 8'h00, 1, 0, crc);
    check("crc_01", crc, 32'h1021);

    // Mixed 3-byte payload, tick every 2nd clk
    run_block(3, 8'hA5, 8'h17, 2, 0, crc);

    // 512 x 0xFF, tick every 4th clk
    run_block(512, 8'hFF, 8'h00, 4, 0, crc);
    check("crc_ff512", crc, 32'h7FA1);
    check("ticks_ff512", oe_ticks, 32'd4114);

    // Start while busy is ignored
    run_block(1, 8'h3C, 8'h00, 1, 6, crc);

    // Underrun: 2-byte block, only one byte supplied
    ce_div = 1;
    pay_q.delete();
    pay_q.push_back(8'h5A);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int k = 7; k >= 0; k--) exp_bits.push_back(pay_q[0][k]);
    tx_q.push_back(8'h5A);
    done_cnt = 0;
    @(negedge clk);
    bus.i_block_size = 12'd2;
    bus.i_start      = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    t = 0;
    while (bus.o_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("unr_idle", {31'd0, bus.o_busy}, 32'd0);
    check("unr_flag", {31'd0, bus.o_underrun}, 32'd1);
    check("unr_nodone", done_cnt, 32'd0);
    check("unr_oe", {31'd0, bus.o_sd_oe}, 32'd0);
    check("unr_dat", {31'd0, bus.o_sd_dat}, 32'd1);
    check("unr_rdy", {31'd0, bus.o_data_rdy}, 32'd1);
    check("unr_bits_left", exp_bits.size(), 32'd0);
    repeat (4) @(negedge clk);
    check("unr_sticky", {31'd0, bus.o_underrun}, 32'd1);
    drain();
    // Next start clears the flag (checked inside launch) and runs normally
    run_block(2, 8'hC3, 8'h11, 1, 0, crc);

    // Abort mid-DATA
    launch(3, 8'h81, 8'h42, 1, crc);
    repeat (12) @(negedge clk);
    bus.i_abort = 1'b1;
    @(posedge clk);
    #1;
    check("abt_dat", {31'd0, bus.o_sd_dat}, 32'd1);
    check("abt_oe", {31'd0, bus.o_sd_oe}, 32'd0);
    check("abt_rdy", {31'd0, bus.o_data_rdy}, 32'd1);
    @(negedge clk);
    bus.i_abort = 1'b0;
    @(negedge clk);
    check("abt_idle", {31'd0, bus.o_busy}, 32'd0);
    check("abt_nodone", done_cnt, 32'd0);
    drain();
    repeat (3) @(negedge clk);

    // Async reset mid-DATA
    launch(2, 8'h96, 8'h01, 1, crc);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_dat", {31'd0, bus.o_sd_dat}, 32'd1);
    check("arst_oe", {31'd0, bus.o_sd_oe}, 32'd0);
    check("arst_rdy", {31'd0, bus.o_data_rdy}, 32'd1);
    check("arst_busy", {31'd0, bus.o_busy}, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Size 0 start is ignored
    bus.i_block_size = 12'd0;
    bus.i_start      = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("size0_busy", {31'd0, bus.o_busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("size0_oe", {31'd0, bus.o_sd_oe}, 32'd0);

    // Still functional afterwards
    run_block(2, 8'h00, 8'hFF, 3, 0, crc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
